cpu_ctrl_fsm: RTL and testbench
===============================

Name: cpu_ctrl_fsm

Overview:
Multi-cycle controller that decodes one 16-bit instruction and drives the datapath control interface: register-file read/write, A/B/C/status loads, operand selects, shift and ALUop. It sits between the instruction register/fetch logic and the existing 16-bit datapath. It sequences MOV-immediate, MOV-register, ADD, CMP, AND and MVN over several clocks. Instructions arrive through a valid/ready handshake, and completion is reported with a one-cycle done pulse.

Parameters:
DATA_W, 16, datapath width and width of sximm8/sximm5 outputs
RN_W, 3, register-number width (8 registers)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instr is valid this cycle
instr  in  16  instruction word
in_ready  out  1  controller idle, can accept instr
done  out  1  one-cycle pulse: instruction finished
illegal  out  1  valid only with done: instruction was not executed
readnum  out  RN_W  register file read address
writenum  out  RN_W  register file write address
write  out  1  register file write enable
vsel  out  2  writeback select: 0=C, 1=PC, 2=mdata, 3=sximm8
asel  out  1  1 = force A operand to 0
bsel  out  1  1 = select sximm5 as B operand
loada / loadb / loadc / loads  out  1 each  pipeline register and status loads
shift  out  2  0=none, 1=LSL1, 2=LSR1, 3=ASR1
ALUop  out  2  0=ADD, 1=SUB, 2=AND, 3=NOT B
sximm8  out  DATA_W  sign-extended instr[7:0] of latched instr
sximm5  out  DATA_W  sign-extended instr[4:0] of latched instr

Behaviour:
- Reset is asynchronous and active-low. One clock, clk.
- Instruction fields: opcode=[15:13], op=[12:11], Rn=[10:8], Rd=[7:5], sh=[4:3], Rm=[2:0].
- Legal opcode/op pairs:
  - 110/10 MOV Rn,#imm8
  - 110/00 MOV Rd,Rm{,sh}
  - 101/00 ADD
  - 101/01 CMP
  - 101/10 AND
  - 101/11 MVN Rd,Rm{,sh}
  - Everything else is illegal.
- Reset (rst_n low, asynchronous):
  - State goes to IDLE and the instruction register clears to 0.
  - All control outputs, done and illegal are 0.
  - in_ready is forced 0 while rst_n is low, and is 1 from the first cycle after release.
- Handshake:
  - in_ready = (state==IDLE). Instr is accepted on the edge where in_valid && in_ready, and latched into the internal IR.
  - instr is ignored in every other state.
  - in_valid held high across done is accepted again only once the state returns to IDLE.
- All control outputs are Moore functions of (state, IR). They are 0 in every state where they are not listed below.
- State transitions and outputs:
  - IDLE: wait for accept, then go to DECODE.
  - DECODE: no outputs. Next state:
    - WIMM for MOV imm
    - GET_B for MOV reg or MVN
    - GET_A for ADD, CMP or AND
    - DONE with illegal for anything else
  - GET_A: readnum=Rn, loada=1. Next: GET_B.
  - GET_B: readnum=Rm, loadb=1. Next: EXEC.
  - EXEC:
    - shift=sh, bsel=0.
    - asel=1 for MOV reg/MVN, else 0.
    - ALUop: ADD=0, CMP=1, AND=2, MVN=3, MOV reg=0.
    - loadc=1 for all except CMP; loads=1 for CMP only.
    - Next: DONE for CMP, otherwise WREG.
  - WREG: writenum=Rd, vsel=0, write=1. Next: DONE.
  - WIMM: writenum=Rn, vsel=3, write=1. Next: DONE.
  - DONE: done=1; illegal=1 if the instruction was illegal. Next: IDLE.
- Latency from the accept edge to the cycle done is high:
  - MOV imm: 3 cycles
  - MOV reg / MVN: 5 cycles
  - CMP: 5 cycles
  - ADD / AND: 6 cycles
  - illegal: 2 cycles
- Throughput: next accept at earliest the cycle after DONE.
- Illegal instructions cause no write, loada, loadb, loadc or loads pulse.
- sximm8 and sximm5 are continuous sign extensions of the IR, e.g. imm8=0xFF gives 0xFFFF.
- Reset mid-instruction: the FSM aborts immediately and no further write occurs. A write that was asserted in the current cycle is dropped because reset deasserts write asynchronously.

Decomposition:
- Package cpu_ctrl_pkg:
  - opcode/op constants
  - state enum (IDLE, DECODE, GET_A, GET_B, EXEC, WREG, WIMM, DONE)
  - ALUop, shift and vsel encodings
  - instruction field slice helpers
- Sub-module instr_decoder: combinational, IR to {opcode, op, Rn, Rd, Rm, sh, sximm8, sximm5, legal}. The FSM instantiates it once.

Test Plan:
- Reset, then instr=0xD32A (MOV R3,#42) -> write=1, vsel=3, writenum=3, sximm8=42 for one cycle, 2 cycles after accept; done 3 cycles after accept with illegal=0.
- 0xA543 (ADD R2,R5,R3) -> loada with readnum=5, then loadb with readnum=3, then loadc with ALUop=0 asel=0 shift=0, then write with writenum=2 vsel=0; done at cycle 6. With the datapath attached and R5=13, R3=42: R2=55.
- 0xB211 (AND R0,R2,R1,LSR#1) then 0xB880 (MVN R4,R0) -> EXEC shift=2 ALUop=2, then MVN asel=1 ALUop=3 writenum=4. With R1=10, R2=20 and the datapath attached: R4=0xFFFB.
- 0xAC06 (CMP R4,R6) -> loads=1 with ALUop=1 in EXEC, loadc and write never asserted, done at cycle 5. With R4=R6 and the datapath attached: Z_out=1.
- 0xD1FF -> sximm8=0xFFFF. 0xE000 (illegal) -> done and illegal both high 2 cycles after accept, with zero write/load pulses.
- Assert rst_n low during GET_B of an ADD -> all outputs 0 immediately and write never pulses. After release, in_ready=1 and 0xD50D completes normally.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the instruction-sequencing controller: opcodes, FSM states,
// datapath select/ALU/shift codes and instruction field helpers.
package cpu_ctrl_pkg;

    localparam int INSTR_W = 16;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_GET_A, S_GET_B, S_EXEC, S_WREG, S_WIMM, S_DONE
    } state_e;

    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_NOTB} alu_op_e;
    typedef enum logic [1:0] {SH_NONE, SH_LSL1, SH_LSR1, SH_ASR1} shift_e;
    typedef enum logic [1:0] {VSEL_C, VSEL_PC, VSEL_MDATA, VSEL_IMM8} vsel_e;

    function automatic logic [2:0] f_opcode(input logic [INSTR_W-1:0] ir);
        return ir[15:13];
    endfunction

    function automatic logic [1:0] f_op(input logic [INSTR_W-1:0] ir);
        return ir[12:11];
    endfunction

    function automatic logic [2:0] f_rn(input logic [INSTR_W-1:0] ir);
        return ir[10:8];
    endfunction

    function automatic logic [2:0] f_rd(input logic [INSTR_W-1:0] ir);
        return ir[7:5];
    endfunction

    function automatic logic [1:0] f_sh(input logic [INSTR_W-1:0] ir);
        return ir[4:3];
    endfunction

    function automatic logic [2:0] f_rm(input logic [INSTR_W-1:0] ir);
        return ir[2:0];
    endfunction

endpackage

// File: rtl/cpu_ctrl_if.sv
// Instruction handshake plus datapath control bundle between fetch, controller and datapath.
interface cpu_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int RN_W   = 3
);
    logic              in_valid;
    logic [15:0]       instr;
    logic              in_ready;
    logic              done;
    logic              illegal;
    logic [RN_W-1:0]   readnum;
    logic [RN_W-1:0]   writenum;
    logic              write;
    logic [1:0]        vsel;
    logic              asel;
    logic              bsel;
    logic              loada;
    logic              loadb;
    logic              loadc;
    logic              loads;
    logic [1:0]        shift;
    logic [1:0]        ALUop;
    logic [DATA_W-1:0] sximm8;
    logic [DATA_W-1:0] sximm5;

    modport master (
        output in_valid, instr,
        input  in_ready, done, illegal, readnum, writenum, write, vsel, asel, bsel,
               loada, loadb, loadc, loads, shift, ALUop, sximm8, sximm5
    );

    modport slave (
        input  in_valid, instr,
        output in_ready, done, illegal, readnum, writenum, write, vsel, asel, bsel,
               loada, loadb, loadc, loads, shift, ALUop, sximm8, sximm5
    );
endinterface

// File: rtl/cpu_ctrl_instr_decoder.sv
// Combinational field extraction, legality check and immediate sign extension of the IR.
module instr_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [INSTR_W-1:0] ir,
    output logic [2:0]         opcode,
    output logic [1:0]         op,
    output logic [2:0]         rn,
    output logic [2:0]         rd,
    output logic [2:0]         rm,
    output logic [1:0]         sh,
    output logic [DATA_W-1:0]  sximm8,
    output logic [DATA_W-1:0]  sximm5,
    output logic               legal
);
    assign opcode = f_opcode(ir);
    assign op     = f_op(ir);
    assign rn     = f_rn(ir);
    assign rd     = f_rd(ir);
    assign rm     = f_rm(ir);
    assign sh     = f_sh(ir);

    // Every ALU-group op is legal; only MOV imm and MOV reg exist in the MOV group.
    assign legal = (opcode == OPC_ALU) ||
                   ((opcode == OPC_MOV) && ((op == OP_MOV_IMM) || (op == OP_MOV_REG)));

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_sx
            if (gi < 8) begin : g_lo8
                assign sximm8[gi] = ir[gi];
            end else begin : g_hi8
                assign sximm8[gi] = ir[7];
            end
            if (gi < 5) begin : g_lo5
                assign sximm5[gi] = ir[gi];
            end else begin : g_hi5
                assign sximm5[gi] = ir[4];
            end
        end
    endgenerate
endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle controller: accepts one instruction, sequences register reads, ALU and
// writeback for MOV/ADD/CMP/AND/MVN, then pulses done.
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int RN_W   = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    cpu_ctrl_if.slave bus
);
    state_e               state_reg, state_next;
    logic [INSTR_W-1:0]   ir_reg;

    logic [2:0]           opcode, rn, rd, rm;
    logic [1:0]           op, sh;
    logic                 legal;
    logic [DATA_W-1:0]    sximm8, sximm5;

    logic [RN_W-1:0]      readnum, writenum;
    logic [1:0]           vsel, shift, alu_op;
    logic                 write, asel, bsel, loada, loadb, loadc, loads, done, illegal;
    logic                 is_cmp, is_mov_imm, is_unary;

    instr_decoder #(.DATA_W(DATA_W)) u_dec (
        .ir     (ir_reg),
        .opcode (opcode),
        .op     (op),
        .rn     (rn),
        .rd     (rd),
        .rm     (rm),
        .sh     (sh),
        .sximm8 (sximm8),
        .sximm5 (sximm5),
        .legal  (legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            ir_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == S_IDLE) && bus.in_valid) begin
                ir_reg <= bus.instr;
            end
        end
    end

    assign is_cmp     = (opcode == OPC_ALU) && (op == OP_CMP);
    assign is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
    // MOV reg and MVN only need the B operand; A is forced to zero.
    assign is_unary   = ((opcode == OPC_MOV) && (op == OP_MOV_REG)) ||
                        ((opcode == OPC_ALU) && (op == OP_MVN));

    always_comb begin
        state_next = state_reg;
        readnum    = '0;
        writenum   = '0;
        write      = 1'b0;
        vsel       = VSEL_C;
        asel       = 1'b0;
        bsel       = 1'b0;
        loada      = 1'b0;
        loadb      = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        shift      = SH_NONE;
        alu_op     = ALU_ADD;
        done       = 1'b0;
        illegal    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (bus.in_valid) state_next = S_DECODE;
            end
            S_DECODE: begin
                if (!legal)          state_next = S_DONE;
                else if (is_mov_imm) state_next = S_WIMM;
                else if (is_unary)   state_next = S_GET_B;
                else                 state_next = S_GET_A;
            end
            S_GET_A: begin
                readnum    = RN_W'(rn);
                loada      = 1'b1;
                state_next = S_GET_B;
            end
            S_GET_B: begin
                readnum    = RN_W'(rm);
                loadb      = 1'b1;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                shift = sh;
                asel  = is_unary;
                if (opcode == OPC_ALU) begin
                    case (op)
                        OP_CMP:  alu_op = ALU_SUB;
                        OP_AND:  alu_op = ALU_AND;
                        OP_MVN:  alu_op = ALU_NOTB;
                        default: alu_op = ALU_ADD;
                    endcase
                end
                loadc      = !is_cmp;
                loads      = is_cmp;
                state_next = is_cmp ? S_DONE : S_WREG;
            end
            S_WREG: begin
                writenum   = RN_W'(rd);
                vsel       = VSEL_C;
                write      = 1'b1;
                state_next = S_DONE;
            end
            S_WIMM: begin
                writenum   = RN_W'(rn);
                vsel       = VSEL_IMM8;
                write      = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                illegal    = !legal;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Gate with rst_n so the source sees not-ready for the whole reset pulse.
    assign bus.in_ready = rst_n && (state_reg == S_IDLE);
    assign bus.done     = done;
    assign bus.illegal  = illegal;
    assign bus.readnum  = readnum;
    assign bus.writenum = writenum;
    assign bus.write    = write;
    assign bus.vsel     = vsel;
    assign bus.asel     = asel;
    assign bus.bsel     = bsel;
    assign bus.loada    = loada;
    assign bus.loadb    = loadb;
    assign bus.loadc    = loadc;
    assign bus.loads    = loads;
    assign bus.shift    = shift;
    assign bus.ALUop    = alu_op;
    assign bus.sximm8   = sximm8;
    assign bus.sximm5   = sximm5;
endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm: per-instruction timeline model checked every cycle,
// a small datapath model driven by the controller, and literal latency/result checks.
module tb_cpu_ctrl_fsm;
    typedef struct packed {
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic [1:0] vsel;
        logic       asel;
        logic       bsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic [1:0] shift;
        logic [1:0] aluop;
        logic       done;
        logic       illegal;
    } ctrl_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    cpu_ctrl_if #(.DATA_W(16), .RN_W(3)) bus ();
    cpu_ctrl_fsm #(.DATA_W(16), .RN_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    ctrl_t       exp_q[$];
    logic [15:0] model_ir = '0;

    logic [15:0] regs[8];
    logic [15:0] dp_a = '0, dp_b = '0, dp_c = '0;
    logic        dp_z = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    function automatic ctrl_t dut_ctrl();
        ctrl_t c;
        c.readnum  = bus.readnum;
        c.writenum = bus.writenum;
        c.write    = bus.write;
        c.vsel     = bus.vsel;
        c.asel     = bus.asel;
        c.bsel     = bus.bsel;
        c.loada    = bus.loada;
        c.loadb    = bus.loadb;
        c.loadc    = bus.loadc;
        c.loads    = bus.loads;
        c.shift    = bus.shift;
        c.aluop    = bus.ALUop;
        c.done     = bus.done;
        c.illegal  = bus.illegal;
        return c;
    endfunction

    // Expected output of every cycle after acceptance, written straight from the instruction's meaning.
    task automatic push_timeline(input logic [15:0] w);
        logic [2:0] opc, rn, rd, rm;
        logic [1:0] op, sh;
        ctrl_t c;
        bit ill;
        opc = w[15:13]; op = w[12:11]; rn = w[10:8]; rd = w[7:5]; sh = w[4:3]; rm = w[2:0];
        ill = 0;
        exp_q.push_back('0);
        if (opc == 3'b110 && op == 2'b10) begin
            c = '0; c.writenum = rn; c.vsel = 2'd3; c.write = 1; exp_q.push_back(c);
        end else if ((opc == 3'b110 && op == 2'b00) || (opc == 3'b101 && op == 2'b11)) begin
            c = '0; c.readnum = rm; c.loadb = 1; exp_q.push_back(c);
            c = '0; c.shift = sh; c.asel = 1; c.aluop = (op == 2'b11) ? 2'd3 : 2'd0; c.loadc = 1;
            exp_q.push_back(c);
            c = '0; c.writenum = rd; c.write = 1; exp_q.push_back(c);
        end else if (opc == 3'b101) begin
            c = '0; c.readnum = rn; c.loada = 1; exp_q.push_back(c);
            c = '0; c.readnum = rm; c.loadb = 1; exp_q.push_back(c);
            c = '0; c.shift = sh;
            c.aluop = (op == 2'b01) ? 2'd1 : (op == 2'b10) ? 2'd2 : 2'd0;
            if (op == 2'b01) c.loads = 1; else c.loadc = 1;
            exp_q.push_back(c);
            if (op != 2'b01) begin
                c = '0; c.writenum = rd; c.write = 1; exp_q.push_back(c);
            end
        end else begin
            ill = 1;
            c = '0; c.done = 1; c.illegal = 1; exp_q.push_back(c);
        end
        if (!ill) begin
            c = '0; c.done = 1; exp_q.push_back(c);
        end
    endtask

    // Model: an instruction is taken only when nothing is in flight.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            exp_q.delete();
            model_ir = '0;
        end else if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end else if (bus.in_valid) begin
            model_ir = bus.instr;
            push_timeline(bus.instr);
        end
    end

    initial forever begin
        ctrl_t req;
        logic  rdy;
        @(negedge clk);
        if (!rst_n) begin
            req = '0; rdy = 1'b0;
        end else begin
            req = (exp_q.size() != 0) ? exp_q[0] : ctrl_t'('0);
            rdy = (exp_q.size() == 0);
        end
        check("ctrl", 32'(dut_ctrl()), 32'(req));
        check("in_ready", 32'(bus.in_ready), 32'(rdy));
        check("sximm8", 32'(bus.sximm8), 32'({{8{model_ir[7]}}, model_ir[7:0]}));
        check("sximm5", 32'(bus.sximm5), 32'({{11{model_ir[4]}}, model_ir[4:0]}));
    end

    // Datapath attached to the controller outputs.
    initial forever begin
        logic [15:0] bsh, ain, bin, res;
        @(posedge clk);
        case (bus.shift)
            2'd1:    bsh = {dp_b[14:0], 1'b0};
            2'd2:    bsh = {1'b0, dp_b[15:1]};
            2'd3:    bsh = {dp_b[15], dp_b[15:1]};
            default: bsh = dp_b;
        endcase
        bin = bus.bsel ? bus.sximm5 : bsh;
        ain = bus.asel ? 16'h0 : dp_a;
        case (bus.ALUop)
            2'd0:    res = ain + bin;
            2'd1:    res = ain - bin;
            2'd2:    res = ain & bin;
            default: res = ~bin;
        endcase
        if (bus.write) regs[bus.writenum] = (bus.vsel == 2'd3) ? bus.sximm8 : dp_c;
        if (bus.loada) dp_a = regs[bus.readnum];
        if (bus.loadb) dp_b = regs[bus.readnum];
        if (bus.loadc) dp_c = res;
        if (bus.loads) dp_z = (res == 16'h0);
    end

    task automatic wait_ready(input string nm);
        bit got;
        got = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin got = 1; break; end
        end
        check({nm, " ready_wait"}, 32'(got), 32'd1);
    endtask

    task automatic issue(input logic [15:0] w, input int lat, input bit exp_ill, input string nm);
        int n, pulses, wr_lc;
        wait_ready(nm);
        bus.in_valid = 1'b1;
        bus.instr    = w;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.instr    = 16'($urandom);
        n = 0; pulses = 0; wr_lc = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            pulses += int'(bus.write) + int'(bus.loada) + int'(bus.loadb) + int'(bus.loadc) + int'(bus.loads);
            wr_lc  += int'(bus.write) + int'(bus.loadc);
            if (w == 16'hD32A && k == 2) begin
                check("movi_wr", 32'({bus.write, bus.vsel, bus.writenum}), 32'({1'b1, 2'd3, 3'd3}));
                check("movi_sximm8", 32'(bus.sximm8), 32'd42);
            end
            if (bus.done) begin
                n = k;
                check({nm, " illegal"}, 32'(bus.illegal), 32'(exp_ill));
                break;
            end
        end
        check({nm, " latency"}, n, lat);
        if (exp_ill) check({nm, " pulses"}, pulses, 0);
        if (w[15:11] == 5'b10101) check({nm, " cmp_no_wr"}, wr_lc, 0);
        $display("instr %h (%s): done after %0d cycles", w, nm, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        for (int i = 0; i < 8; i++) regs[i] = '0;
        bus.in_valid = 1'b0;
        bus.instr    = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("ready_in_reset", 32'(bus.in_ready), 32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(bus.in_ready), 32'd1);

        issue(16'hD32A, 3, 0, "MOV R3,#42");
        issue(16'hD50D, 3, 0, "MOV R5,#13");
        issue(16'hA543, 6, 0, "ADD R2,R5,R3");
        check("R2_sum", 32'(regs[2]), 32'd55);

        issue(16'hD10A, 3, 0, "MOV R1,#10");
        issue(16'hD214, 3, 0, "MOV R2,#20");
        issue(16'hB211, 6, 0, "AND R0,R2,R1,LSR1");
        check("R0_and", 32'(regs[0]), 32'd4);
        issue(16'hB880, 5, 0, "MVN R4,R0");
        check("R4_mvn", 32'(regs[4]), 32'hFFFB);

        issue(16'hD6FB, 3, 0, "MOV R6,#-5");
        check("R6_neg", 32'(regs[6]), 32'hFFFB);
        issue(16'hAC06, 5, 0, "CMP R4,R6");
        check("Z_cmp", 32'(dp_z), 32'd1);

        // in_valid held high across done: re-accepted only from IDLE.
        wait_ready("held");
        bus.in_valid = 1'b1;
        bus.instr    = 16'hD1FF;
        repeat (9) @(negedge clk);
        bus.in_valid = 1'b0;
        wait_ready("held_end");
        check("sximm8_ff", 32'(bus.sximm8), 32'hFFFF);
        check("R1_ff", 32'(regs[1]), 32'hFFFF);

        issue(16'hE000, 2, 1, "illegal E000");
        issue(16'hC800, 2, 1, "illegal C800");

        // Abort an ADD R7,R5,R3 during its B-operand read.
        wait_ready("abort");
        bus.in_valid = 1'b1;
        bus.instr    = 16'hA5E3;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        found = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.loadb) begin found = 1; break; end
        end
        check("abort_reach_getb", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_ctrl_zero", 32'(dut_ctrl()), 32'd0);
        check("abort_ready_zero", 32'(bus.in_ready), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready_after", 32'(bus.in_ready), 32'd1);
        $display("reset during ADD R7: aborted");
        issue(16'hD50D, 3, 0, "MOV R5,#13 after reset");
        check("R7_unwritten", 32'(regs[7]), 32'd0);
        check("R5_imm", 32'(regs[5]), 32'd13);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
